// File: rtl/pll_reseq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// The counter-width helper sizes a counter to hold the largest of three cycle counts.
package pll_reseq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    SDRAM_EN  = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  localparam int RETRY_SAT = 15;

  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer, async active-low reset to 0.
// Output follows the input two clk edges later; no handshake.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset, filtered lock, then SDRAM clock enable, then SoC reset release.
// PLL_RESEQ_RETRY_EN: a lock timeout re-resets the PLL and counts retries; otherwise it only flags.
module pll_reset_sequencer
  import pll_reseq_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int SDRAM_DLY    = 32,
  parameter int CNT_W        = cnt_w(RST_CYCLES, LOCK_TIMEOUT, SDRAM_DLY)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic       sdram_clk_en,
  output logic       sys_resetn,
  output logic       lock_ok,
  output logic       lock_timeout,
  output logic [3:0] retry_cnt
);

  localparam int FILT_W = cnt_w(LOCK_FILTER, 1, 1);

  pll_state_t        r_state;
  pll_state_t        w_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [FILT_W-1:0] r_filt;
  logic              w_lock_s;
  logic              w_filt_done;
  logic              w_to_set;
  logic              r_pll_resetb;
  logic              r_sdram_clk_en;
  logic              r_sys_resetn;
  logic              r_lock_ok;
  logic              r_lock_timeout;

  sync_2ff u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_d     (pll_lock),
    .o_q     (w_lock_s)
  );

  // Filter completes on the LOCK_FILTER-th consecutive synchronized-high cycle.
  assign w_filt_done = w_lock_s && (r_filt == FILT_W'(LOCK_FILTER - 1));
  assign w_to_set    = (r_state == WAIT_LOCK) && (r_cnt == CNT_W'(LOCK_TIMEOUT - 1));

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == CNT_W'(RST_CYCLES - 1)) w_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_filt_done) begin
          w_nxt = SDRAM_EN;
        end
`ifdef PLL_RESEQ_RETRY_EN
        else if (w_to_set) begin
          w_nxt = PLL_RST;
        end
`endif
      end
      SDRAM_EN: begin
        if (!w_lock_s)                            w_nxt = WAIT_LOCK;
        else if (r_cnt == CNT_W'(SDRAM_DLY - 1))  w_nxt = RUN;
      end
      RUN: begin
        if (!w_lock_s) w_nxt = WAIT_LOCK;
      end
      default: w_nxt = PLL_RST;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= PLL_RST;
      r_cnt          <= '0;
      r_filt         <= '0;
      r_pll_resetb   <= 1'b0;
      r_sdram_clk_en <= 1'b0;
      r_sys_resetn   <= 1'b0;
      r_lock_ok      <= 1'b0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_state <= w_nxt;
      // Counter parks at LOCK_TIMEOUT-1 when a timeout does not leave WAIT_LOCK.
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if ((r_state != RUN) && !w_to_set)
        r_cnt <= r_cnt + 1'b1;
      if ((r_state == WAIT_LOCK) && (w_nxt == WAIT_LOCK) && w_lock_s)
        r_filt <= r_filt + 1'b1;
      else
        r_filt <= '0;
      r_lock_timeout <= r_lock_timeout | w_to_set;
      r_pll_resetb   <= (w_nxt != PLL_RST);
      r_sdram_clk_en <= (w_nxt == SDRAM_EN) || (w_nxt == RUN);
      r_sys_resetn   <= (w_nxt == RUN);
      r_lock_ok      <= (w_nxt == RUN);
    end
  end

`ifdef PLL_RESEQ_RETRY_EN
  logic [3:0] r_retry;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_retry <= '0;
    else if ((r_state == WAIT_LOCK) && (w_nxt == PLL_RST) && (r_retry != 4'(RETRY_SAT)))
      r_retry <= r_retry + 4'd1;
  end

  assign retry_cnt = r_retry;
`else
  assign retry_cnt = 4'd0;
`endif

  assign pll_resetb   = r_pll_resetb;
  assign sdram_clk_en = r_sdram_clk_en;
  assign sys_resetn   = r_sys_resetn;
  assign lock_ok      = r_lock_ok;
  assign lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock activity,
// every cycle compared against a phase/elapsed-time model of the sequencing rules.
module tb_pll_reset_sequencer;

  localparam int RST_C = 4;
  localparam int FILT  = 8;
  localparam int TO    = 32;
  localparam int DLY   = 5;
`ifdef PLL_RESEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  localparam int PH_HOLD  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_SDRAM = 2;
  localparam int PH_RUN   = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_resetb, sdram_clk_en, sys_resetn, lock_ok, lock_timeout;
  logic [3:0] retry_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int   m_phase, m_age, m_run, m_retry;
  logic m_to, m_s1, m_s2;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_CYCLES   (RST_C),
    .LOCK_FILTER  (FILT),
    .LOCK_TIMEOUT (TO),
    .SDRAM_DLY    (DLY),
    .CNT_W        (6)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pll_lock     (pll_lock),
    .pll_resetb   (pll_resetb),
    .sdram_clk_en (sdram_clk_en),
    .sys_resetn   (sys_resetn),
    .lock_ok      (lock_ok),
    .lock_timeout (lock_timeout),
    .retry_cnt    (retry_cnt)
  );

  function automatic logic [31:0] dut_vec();
    return {23'd0, pll_resetb, sdram_clk_en, sys_resetn, lock_ok, lock_timeout, retry_cnt};
  endfunction

  function automatic logic [31:0] model_vec();
    logic run_ph;
    run_ph = (m_phase == PH_RUN);
    return {23'd0, m_phase != PH_HOLD, (m_phase == PH_SDRAM) || run_ph, run_ph, run_ph,
            m_to, 4'(m_retry)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_HOLD; m_age = 0; m_run = 0; m_retry = 0;
    m_to = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  // m_age = edges already spent in the current phase; this edge is number m_age+1.
  task automatic model_edge();
    logic ls;
    int   nph;
    ls = m_s2;
    nph = m_phase;
    m_s2 = m_s1;
    m_s1 = pll_lock;
    case (m_phase)
      PH_HOLD: if (m_age + 1 == RST_C) nph = PH_WAIT;
      PH_WAIT: begin
        m_run = ls ? m_run + 1 : 0;
        if (m_age + 1 >= TO) m_to = 1'b1;
        if (m_run >= FILT) nph = PH_SDRAM;
        else if (RETRY && (m_age + 1 >= TO)) begin
          nph = PH_HOLD;
          m_retry = (m_retry < 15) ? m_retry + 1 : 15;
        end
      end
      PH_SDRAM: begin
        if (!ls) nph = PH_WAIT;
        else if (m_age + 1 == DLY) nph = PH_RUN;
      end
      default: if (!ls) nph = PH_WAIT;
    endcase
    if (nph != m_phase) begin
      m_phase = nph; m_age = 0; m_run = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic tick(input logic lk);
    pll_lock = lk;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("model", dut_vec(), model_vec());
  endtask

  // Called at posedge+1: reset lands mid-cycle, released one edge later.
  task automatic mid_reset();
    #3;
    resetn = 1'b0;
    #1;
    check("async_rst", dut_vec(), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int k, t_rb, t_sd, t_sys, seg_len;
    logic seg_lvl;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_vals", dut_vec(), 32'd0);
    resetn = 1'b1;
    cyc = 0;
    check("cycle0", dut_vec(), 32'd0);

    // Clean start, lock raised at cycle 10.
    t_rb = -1; t_sd = -1; t_sys = -1;
    for (int i = 0; i < 30; i++) begin
      tick(cyc >= 10);
      if (pll_resetb && t_rb < 0) t_rb = cyc;
      if (sdram_clk_en && t_sd < 0) t_sd = cyc;
      if (sys_resetn && t_sys < 0) t_sys = cyc;
    end
    check("resetb_rise", t_rb, 4);
    check("sdram_rise", t_sd, 20);
    check("sys_rise", t_sys, 25);

    // Lock lost for 2 cycles while in RUN.
    k = cyc;
    tick(1'b0);
    tick(1'b0);
    check("loss_plus2", {sys_resetn, sdram_clk_en, lock_ok}, 3'b111);
    tick(1'b1);
    check("loss_plus3", {sys_resetn, sdram_clk_en, lock_ok}, 3'b000);
    t_sd = -1; t_sys = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      if (sdram_clk_en && t_sd < 0) t_sd = cyc - k;
      if (sys_resetn && t_sys < 0) t_sys = cyc - k;
    end
    check("reseq_sdram", t_sd, 12);
    check("reseq_sys", t_sys, 17);

    // Lock held low: timeout after 32 WAIT_LOCK cycles, then retries or parking.
    k = cyc;
    for (int i = 0; i < 700; i++) begin
      tick(1'b0);
      if (cyc == k + 34) check("to_before", lock_timeout, 1'b0);
      if (cyc == k + 35) check("to_set", {lock_timeout, pll_resetb}, {1'b1, !RETRY});
      if (cyc == k + 36) check("retry_first", retry_cnt, RETRY ? 4'd1 : 4'd0);
      if (cyc == k + 39) check("resetb_back", pll_resetb, 1'b1);
    end
    check("retry_sat", retry_cnt, RETRY ? 4'd15 : 4'd0);

    // Recover lock, then hit async reset while in SDRAM_EN.
    t_sd = -1;
    for (int i = 0; i < 100 && t_sd < 0; i++) begin
      tick(1'b1);
      if (sdram_clk_en) t_sd = cyc;
    end
    check("recover_found", t_sd >= 0, 1'b1);
    tick(1'b1);
    tick(1'b1);
    check("sticky_to", lock_timeout, 1'b1);
    pll_lock = 1'b0;
    mid_reset();
    check("to_cleared", lock_timeout, 1'b0);

    // Chatter: high 6, low 1, then high.
    t_sd = -1;
    for (int i = 0; i < 30; i++) begin
      tick(((cyc >= 6) && (cyc <= 11)) || (cyc >= 13));
      if (sdram_clk_en && t_sd < 0) t_sd = cyc;
    end
    check("chatter_sdram", t_sd, 23);

    // Filter completes on the exact timeout edge.
    pll_lock = 1'b0;
    mid_reset();
    for (int i = 0; i < 40; i++) begin
      tick(cyc >= 26);
      if (cyc == 35) check("simul_pre", {lock_timeout, sdram_clk_en}, 2'b00);
      if (cyc == 36) check("simul_edge", {sdram_clk_en, pll_resetb, lock_timeout, retry_cnt}, 7'b1110000);
    end

    // Random lock activity with occasional mid-cycle resets.
    for (int s = 0; s < 120; s++) begin
      seg_lvl = 1'($urandom_range(0, 1));
      seg_len = int'($urandom_range(1, 45));
      if ($urandom_range(0, 11) == 0) mid_reset();
      for (int i = 0; i < seg_len; i++) tick(seg_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
